// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, constants and state type for the fetch stage
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  typedef enum logic [1:0] {RUN, FLUSH, FAULT} fetch_state_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction memory, decode handoff and redirect signals of the fetch stage
interface fetch_if;
  import fetch_pkg::*;
  logic imem_en;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] instruction;
  logic [XLEN-1:0] instruction_pc;
  logic instruction_RDY_BSY;
  logic decode_ready;
  logic branch_taken;
  logic [XLEN-1:0] branch_target;
  logic fetch_fault;
  modport master(
    output imem_en, imem_addr, instruction, instruction_pc, instruction_RDY_BSY, fetch_fault,
    input imem_rdata, decode_ready, branch_taken, branch_target
  );
  modport slave(
    input imem_en, imem_addr, instruction, instruction_pc, instruction_RDY_BSY, fetch_fault,
    output imem_rdata, decode_ready, branch_taken, branch_target
  );
endinterface

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry word+PC holding slot with load, drain and flush
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            drain,
  input  logic            flush,
  input  logic [XLEN-1:0] d_word,
  input  logic [XLEN-1:0] d_pc,
  output logic            skid_v,
  output logic [XLEN-1:0] q_word,
  output logic [XLEN-1:0] q_pc
);
  logic v_q, v_d;
  logic [XLEN-1:0] word_q, word_d, pc_q, pc_d;
  always_comb begin
    v_d = flush ? 1'b0 : load | (v_q & !drain);
    word_d = load ? d_word : word_q;
    pc_d = load ? d_pc : pc_q;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      v_q <= 1'b0;
      word_q <= NOP_INSTR;
      pc_q <= '0;
    end else begin
      v_q <= v_d;
      word_q <= word_d;
      pc_q <= pc_d;
    end
  assign skid_v = v_q;
  assign q_word = word_q;
  assign q_pc = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, credit-limited imem issue, output register and redirect FSM.
// FETCH_MISALIGN_TRAP_EN: misaligned redirect targets fault instead of being truncated.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  fetch_if.master bus
);
  fetch_state_t st_q, st_d;
  logic [XLEN-1:0] pc_q, pc_d, out_q, out_d, out_pc_q, out_pc_d, pend_pc_q, pend_pc_d;
  logic [XLEN-1:0] skid_q, skid_pc, target;
  logic out_v_q, out_v_d, pend_q, pend_d, skid_v;
  logic consume, redirect, misalign, issue, out_free, skid_load, skid_drain;
  logic [1:0] occ;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign = |bus.branch_target[1:0];
  assign bus.fetch_fault = st_q == FAULT;
`else
  assign misalign = 1'b0;
  assign bus.fetch_fault = 1'b0;
`endif
  assign target = bus.branch_target & ~32'd3;
  always_comb begin
    consume = out_v_q & bus.decode_ready;
    redirect = (st_q != FAULT) & bus.branch_taken;
    occ = 2'(out_v_q) + 2'(skid_v) + 2'(pend_q) - 2'(consume);
    issue = rst & (st_q != FAULT) & !bus.branch_taken & (occ < 2'd2);
    out_free = !out_v_q | consume;
    skid_drain = out_free & skid_v;
    // a response bypasses the skid only when nothing older is waiting in it
    skid_load = pend_q & !redirect & !(out_free & !skid_v);
    out_v_d = redirect ? 1'b0 : out_free ? (skid_v | pend_q) : 1'b1;
    out_d = skid_drain ? skid_q : (out_free & pend_q) ? bus.imem_rdata : out_q;
    out_pc_d = skid_drain ? skid_pc : (out_free & pend_q) ? pend_pc_q : out_pc_q;
    pend_d = issue;
    pend_pc_d = issue ? pc_q : pend_pc_q;
    pc_d = (redirect & !misalign) ? target : issue ? pc_q + PC_STEP : pc_q;
    st_d = redirect ? (misalign ? FAULT : FLUSH) : (st_q == FLUSH) ? RUN : st_q;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      st_q <= RUN;
      pc_q <= RESET_PC;
      out_v_q <= 1'b0;
      out_q <= NOP_INSTR;
      out_pc_q <= '0;
      pend_q <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      st_q <= st_d;
      pc_q <= pc_d;
      out_v_q <= out_v_d;
      out_q <= out_d;
      out_pc_q <= out_pc_d;
      pend_q <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  fetch_skid_buffer u_skid (
    .clk(clk),
    .rst(rst),
    .load(skid_load),
    .drain(skid_drain),
    .flush(redirect),
    .d_word(bus.imem_rdata),
    .d_pc(pend_pc_q),
    .skid_v(skid_v),
    .q_word(skid_q),
    .q_pc(skid_pc)
  );
  assign bus.imem_en = issue;
  assign bus.imem_addr = pc_q;
  assign bus.instruction = out_q;
  assign bus.instruction_pc = out_pc_q;
  assign bus.instruction_RDY_BSY = out_v_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with an in-flight word queue model checked every cycle
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  fetch_if bus ();
  fetch_unit #(.RESET_PC(RST_PC)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) bus.imem_rdata <= bus.imem_en ? bus.imem_addr : 32'hDEAD_BEEF;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // model: every issued word is queued with its issue cycle; it is presentable two cycles later
  logic [31:0] q_pc[$];
  int q_cyc[$];
  int cyc = 0;
  logic [31:0] fetch_ptr = RST_PC;
  bit fault_m = 1'b0;
  bit was_rst = 1'b1;
  bit exp_v, cons, exp_en;
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      chk("en_in_reset", 32'(bus.imem_en), 32'd0);
      q_pc.delete();
      q_cyc.delete();
      fetch_ptr = RST_PC;
      fault_m = 1'b0;
      was_rst = 1'b1;
    end else begin
      if (was_rst) begin
        chk("rst_valid", 32'(bus.instruction_RDY_BSY), 32'd0);
        chk("rst_instr", bus.instruction, 32'h0000_0013);
        chk("rst_pc", bus.instruction_pc, 32'd0);
        chk("rst_fault", 32'(bus.fetch_fault), 32'd0);
      end
      was_rst = 1'b0;
      exp_v = !fault_m && q_pc.size() > 0 && q_cyc[0] <= cyc - 2;
      chk("valid", 32'(bus.instruction_RDY_BSY), 32'(exp_v));
      if (exp_v && bus.instruction_RDY_BSY) begin
        chk("instr_pc", bus.instruction_pc, q_pc[0]);
        chk("instr", bus.instruction, q_pc[0]);
      end
      chk("fault", 32'(bus.fetch_fault), 32'(fault_m));
      cons = exp_v & bus.decode_ready;
      exp_en = 1'b0;
      if (!fault_m) begin
        if (bus.branch_taken) begin
          q_pc.delete();
          q_cyc.delete();
          if (TRAP && bus.branch_target[1:0] != 2'b00) fault_m = 1'b1;
          else fetch_ptr = bus.branch_target & ~32'd3;
        end else begin
          if (cons) begin
            void'(q_pc.pop_front());
            void'(q_cyc.pop_front());
          end
          exp_en = q_pc.size() < 2;
          if (exp_en) begin
            if (bus.imem_en) chk("imem_addr", bus.imem_addr, fetch_ptr);
            q_pc.push_back(fetch_ptr);
            q_cyc.push_back(cyc);
            fetch_ptr += 32'd4;
          end
        end
      end
      chk("imem_en", 32'(bus.imem_en), 32'(exp_en));
    end
  end
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  logic [31:0] held;
  initial begin
    rst = 1'b0;
    bus.decode_ready = 1'b1;
    bus.branch_taken = 1'b0;
    bus.branch_target = '0;
    step(2);
    rst = 1'b1;
    @(negedge clk); chk("c0_en", 32'(bus.imem_en), 32'd1); chk("c0_addr", bus.imem_addr, 32'h100);
    step(); @(negedge clk); chk("c1_addr", bus.imem_addr, 32'h104); chk("c1_valid", 32'(bus.instruction_RDY_BSY), 32'd0);
    step(); @(negedge clk); chk("c2_valid", 32'(bus.instruction_RDY_BSY), 32'd1); chk("c2_instr", bus.instruction, 32'h100);
    step(); @(negedge clk); chk("c3_instr", bus.instruction, 32'h104);
    step(3);
    bus.decode_ready = 1'b0;
    @(negedge clk); held = bus.instruction;
    for (int i = 1; i < 5; i++) begin
      step(); @(negedge clk);
      chk("stall_en", 32'(bus.imem_en), 32'd0);
      chk("stall_hold", bus.instruction, held);
    end
    step(); bus.decode_ready = 1'b1;
    @(negedge clk); chk("release_instr", bus.instruction, held);
    step(); @(negedge clk); chk("release_next", bus.instruction, held + 32'd4);
    step(4);
    bus.decode_ready = 1'b0;
    step(3);
    bus.branch_taken = 1'b1; bus.branch_target = 32'h200; bus.decode_ready = 1'b1;
    @(negedge clk); chk("redir_en", 32'(bus.imem_en), 32'd0);
    step(); bus.branch_taken = 1'b0;
    @(negedge clk); chk("t1_addr", bus.imem_addr, 32'h200); chk("t1_valid", 32'(bus.instruction_RDY_BSY), 32'd0);
    step(); @(negedge clk); chk("t2_valid", 32'(bus.instruction_RDY_BSY), 32'd0);
    step(); @(negedge clk); chk("t3_valid", 32'(bus.instruction_RDY_BSY), 32'd1); chk("t3_pc", bus.instruction_pc, 32'h200);
    step(4);
    bus.branch_taken = 1'b1; bus.branch_target = 32'h300;
    step(); bus.branch_target = 32'h400;
    step(); bus.branch_taken = 1'b0;
    @(negedge clk); chk("latest_target", bus.imem_addr, 32'h400);
    step(4);
    bus.branch_taken = 1'b1; bus.branch_target = 32'hFFFF_FFF8;
    step(); bus.branch_taken = 1'b0;
    @(negedge clk); chk("wrap0", bus.imem_addr, 32'hFFFF_FFF8);
    step(); @(negedge clk); chk("wrap1", bus.imem_addr, 32'hFFFF_FFFC);
    step(); @(negedge clk); chk("wrap2", bus.imem_addr, 32'h0000_0000);
    step(4);
    bus.decode_ready = 1'b0; rst = 1'b0;
    step(); rst = 1'b1; bus.decode_ready = 1'b1;
    @(negedge clk); chk("mid_rst_addr", bus.imem_addr, RST_PC); chk("mid_rst_instr", bus.instruction, 32'h13);
    step(3); bus.decode_ready = 1'b0;
    step(2); bus.decode_ready = 1'b1;
    step(3);
    bus.branch_taken = 1'b1; bus.branch_target = 32'h202;
    step(); bus.branch_taken = 1'b0;
    @(negedge clk);
    if (TRAP) begin
      chk("trap_fault", 32'(bus.fetch_fault), 32'd1);
      chk("trap_en", 32'(bus.imem_en), 32'd0);
      bus.branch_taken = 1'b1; bus.branch_target = 32'h300;
      for (int i = 0; i < 3; i++) begin
        step(); @(negedge clk);
        chk("trap_stuck_v", 32'(bus.instruction_RDY_BSY), 32'd0);
        chk("trap_stuck_en", 32'(bus.imem_en), 32'd0);
      end
      bus.branch_taken = 1'b0;
    end else begin
      chk("misalign_addr", bus.imem_addr, 32'h200);
      chk("misalign_fault", 32'(bus.fetch_fault), 32'd0);
      step(2); @(negedge clk); chk("misalign_pc", bus.instruction_pc, 32'h200);
    end
    step(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
